alu_bit_serial: RTL and testbench

Bit-serial WIDTH-bit ALU sequencer. It drives one instance of the team's 1-bit slice `alu_top` across WIDTH cycles, LSB first, and sets the slice's A_invert, B_invert, operation, cin and less inputs from a 4-bit ALU_control code. It collects the slice's result and cout outputs into a WIDTH-bit result with zero, cout and overflow flags. It is the area-minimal alternative to the ripple-array ALU and uses a start/busy/done handshake.

---
 rtl/alu_pkg.sv | 67 ++++++
 rtl/alu_top.sv | 34 +++
 rtl/alu_bit_serial.sv | 141 ++++++++++++++
 tb/tb_alu_bit_serial.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
// Control codes, FSM states and the slice control decode.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic       a_inv;
    logic       b_inv;
    logic [1:0] op;
    logic       cin;
    logic       arith;
    logic       slt;
    logic       valid;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [3:0] code);
    ctrl_t c;
    c       = '0;
    c.op    = OP_AND;
    c.valid = 1'b1;
    case (code)
      ALU_AND: c.op = OP_AND;
      ALU_OR:  c.op = OP_OR;
      ALU_ADD: begin
        c.op    = OP_ADD;
        c.arith = 1'b1;
      end
      ALU_SUB: begin
        c.b_inv = 1'b1;
        c.op    = OP_ADD;
        c.cin   = 1'b1;
        c.arith = 1'b1;
      end
      ALU_SLT: begin
        c.b_inv = 1'b1;
        c.op    = OP_ADD;
        c.cin   = 1'b1;
        c.arith = 1'b1;
        c.slt   = 1'b1;
      end
      ALU_NOR: begin
        c.a_inv = 1'b1;
        c.b_inv = 1'b1;
        c.op    = OP_AND;
      end
      default: c.valid = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_top.sv
// 1-bit ALU slice: optional input inversion, then AND/OR/ADD/LESS.
// Carry out is always the full-adder carry of the inverted inputs.
module alu_top (
  input  logic       src1,
  input  logic       src2,
  input  logic       less,
  input  logic       A_invert,
  input  logic       B_invert,
  input  logic       cin,
  input  logic [1:0] operation,
  output logic       result,
  output logic       cout
);

  logic a;
  logic b;

  assign a = src1 ^ A_invert;
  assign b = src2 ^ B_invert;

  // Select the slice function
  always_comb begin
    result = 1'b0;
    case (operation)
      2'b00:   result = a & b;
      2'b01:   result = a | b;
      2'b10:   result = a ^ b ^ cin;
      default: result = less;
    endcase
  end

  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/alu_bit_serial.sv
// Bit-serial ALU: walks one alu_top slice across WIDTH bits,
// LSB first, with a start/busy/done handshake.
module alu_bit_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  state_e           state_q, state_d;
  ctrl_t            ctl_q;
  logic [WIDTH-1:0] a_q, b_q, sr_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic             cin_msb_q, sum_msb_q;

  logic [WIDTH-1:0] res_q;
  logic             done_q, zero_q, cout_q, ovf_q;

  logic             accept, last;
  logic             sl_res, sl_cout;
  logic [WIDTH-1:0] fin_res;
  logic             fin_cout, fin_ovf;

  assign accept = (state_q == S_IDLE) && start;
  assign last   = (idx_q == LAST);

  alu_top u_slice (
    .src1      (a_q[idx_q]),
    .src2      (b_q[idx_q]),
    .less      (1'b0),
    .A_invert  (ctl_q.a_inv),
    .B_invert  (ctl_q.b_inv),
    .cin       (carry_q),
    .operation (ctl_q.op),
    .result    (sl_res),
    .cout      (sl_cout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN:  if (last)  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latch, bit walk, carry chain and result shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sr_q      <= '0;
      ctl_q     <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      cin_msb_q <= 1'b0;
      sum_msb_q <= 1'b0;
    end else if (accept) begin
      a_q     <= src1;
      b_q     <= src2;
      ctl_q   <= decode(ALU_control);
      idx_q   <= '0;
      carry_q <= decode(ALU_control).cin;
    end else if (state_q == S_RUN) begin
      sr_q    <= {sl_res, sr_q[WIDTH-1:1]};
      carry_q <= sl_cout;
      idx_q   <= idx_q + IW'(1);
      if (last) begin
        cin_msb_q <= carry_q;
        sum_msb_q <= sl_res;
      end
    end
  end

  // Final result and flags from the collected bits
  always_comb begin
    fin_ovf  = 1'b0;
    fin_cout = 1'b0;
    fin_res  = sr_q;
    if (ctl_q.valid && ctl_q.arith) begin
      fin_ovf  = cin_msb_q ^ carry_q;
      fin_cout = carry_q;
    end
    if (!ctl_q.valid)
      fin_res = '0;
    else if (ctl_q.slt)
      fin_res = {{(WIDTH-1){1'b0}}, sum_msb_q ^ fin_ovf};
  end

  // Output registers, loaded only at the done edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      res_q  <= '0;
      zero_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        res_q  <= fin_res;
        zero_q <= (fin_res == '0);
        cout_q <= fin_cout;
        ovf_q  <= fin_ovf;
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign result   = res_q;
  assign zero     = zero_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_bit_serial.sv
// Directed and random checks of alu_bit_serial against an
// arithmetic reference model.
module tb_alu_bit_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [3:0]  ALU_control = '0;
  logic        busy, done, zero, cout, overflow;
  logic [31:0] result;

  int passes = 0;
  int total  = 0;

  alu_bit_serial #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .src1        (src1),
    .src2        (src2),
    .ALU_control (ALU_control),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .zero        (zero),
    .cout        (cout),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model(input logic [31:0] a, b, input logic [3:0] code,
                       output logic [31:0] r, output logic c, v);
    logic [32:0] s;
    r = '0; c = 1'b0; v = 1'b0;
    case (code)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      4'b0110, 4'b0111: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        c = s[32];
        v = (a[31] != b[31]) && (s[31] != a[31]);
        r = (code == 4'b0110) ? s[31:0]
                              : {31'd0, $signed(a) < $signed(b)};
      end
      default: r = '0;
    endcase
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] a, b,
                            input logic [3:0] code);
    logic [31:0] er;
    logic ec, ev;
    model(a, b, code, er, ec, ev);
    chk({tag, ".result"}, result, er);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, er == 32'd0});
    chk({tag, ".cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, ev});
  endtask

  task automatic run_op(input logic [31:0] a, b, input logic [3:0] code,
                        input bit poke, input string tag);
    int n;
    @(negedge clk);
    src1 = a; src2 = b; ALU_control = code; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src1 = $urandom; src2 = $urandom; ALU_control = 4'($urandom);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 100) begin
      start = poke && (n == 5);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, n, 32'd33);
    chk({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    check_outs(tag, a, b, code);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    check_outs({tag, ".hold"}, a, b, code);
  endtask

  initial begin
    int n;
    logic [3:0] codes [8];
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
              4'b0111, 4'b1100, 4'b1111, 4'b0011};

    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.flags", {29'd0, zero, cout, overflow}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op(32'h7FFFFFFF, 32'h00000001, 4'b0010, 0, "add_ovf");
    run_op(32'd5, 32'd5, 4'b0110, 0, "sub_eq");
    run_op(32'hFFFFFFFF, 32'h00000001, 4'b0111, 0, "slt_neg");
    run_op(32'h7FFFFFFF, 32'h80000000, 4'b0111, 0, "slt_ovf");
    run_op(32'h0F0F0000, 32'h00000F0F, 4'b1100, 0, "nor");
    run_op(32'h0F0F0000, 32'h00000F0F, 4'b0000, 0, "and");
    run_op(32'h0F0F0000, 32'h00000F0F, 4'b0001, 0, "or");
    run_op(32'h12345678, 32'h9ABCDEF0, 4'b1111, 0, "invalid");
    run_op(32'h00001234, 32'h00004321, 4'b0010, 1, "poke_run");
    run_op(32'h80000000, 32'h80000000, 4'b0010, 0, "after_poke");

    for (int i = 0; i < 12; i++)
      run_op($urandom, $urandom, codes[$urandom_range(0, 7)], 0, "rand");

    // start held through done: second op accepted the cycle after done
    @(negedge clk);
    src1 = 32'd100; src2 = 32'd23; ALU_control = 4'b0110; start = 1'b1;
    @(posedge clk); #1;
    wait_done(n);
    chk("b2b.lat1", n, 32'd33);
    check_outs("b2b.op1", 32'd100, 32'd23, 4'b0110);
    chk("b2b.idle_at_done", {31'd0, busy}, 32'd0);
    src1 = 32'hFFFF0000; src2 = 32'h0000FFFF; ALU_control = 4'b0001;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b.accept", {31'd0, busy}, 32'd1);
    wait_done(n);
    chk("b2b.lat2", n, 32'd33);
    check_outs("b2b.op2", 32'hFFFF0000, 32'h0000FFFF, 4'b0001);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    src1 = 32'hDEADBEEF; src2 = 32'h11111111; ALU_control = 4'b0010;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.busy", {31'd0, busy}, 32'd0);
    chk("arst.done", {31'd0, done}, 32'd0);
    chk("arst.result", result, 32'd0);
    chk("arst.flags", {29'd0, zero, cout, overflow}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("arst.no_done", {31'd0, done}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op(32'd3, 32'd4, 4'b0010, 0, "post_rst");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
